// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS control path: FSM state
// encoding, opcode/funct constants, datapath mux/ALU-op encodings, the
// packed control vector, and the DECODE-state dispatch function.
// The ALU-control and datapath mux blocks import these same encodings.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

  // FSM states; IDLE must be 0 and HALT must be 15.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_R_EXEC   = 4'd7,
    ST_R_WB     = 4'd8,
    ST_I_EXEC   = 4'd9,
    ST_I_WB     = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_JAL      = 4'd13,
    ST_JR       = 4'd14,
    ST_HALT     = 4'd15
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Funct codes (IR[5:0]) that the controller itself cares about
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // ALU operation select
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_LUI   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  // ALU B operand select
  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_ONE  = 2'd1;
  localparam logic [1:0] SRCB_SEXT = 2'd2;
  localparam logic [1:0] SRCB_ZEXT = 2'd3;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REG    = 2'd3;

  // Register-file write address select
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  // Register-file write data select
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  // Full control vector produced each cycle by the output decoder.
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  // State reached from DECODE for a given opcode/funct. Anything not
  // recognised lands in HALT.
  function automatic state_e decode_next(input logic [5:0] opcode,
                                         input logic [5:0] funct);
    state_e nxt;
    case (opcode)
      OP_RTYPE:                nxt = (funct == FUNCT_JR) ? ST_JR : ST_R_EXEC;
      OP_LW, OP_SW:            nxt = ST_MEM_ADDR;
      OP_ADDI, OP_ORI, OP_LUI: nxt = ST_I_EXEC;
      OP_BEQ, OP_BNE:          nxt = ST_BRANCH;
      OP_J:                    nxt = ST_JUMP;
      OP_JAL:                  nxt = ST_JAL;
      default:                 nxt = ST_HALT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// -----------------------------------------------------------------------------
// mc_output_decode
// Purely combinational control-vector decode for the multi-cycle MIPS
// controller. Everything is a function of the current state; opcode picks
// the per-instruction variants, zero qualifies branch PC writes and
// mem_ready qualifies the FETCH writes and the MEM_WR completion.
//
// Ports:
//   state_i     current FSM state
//   opcode_i    IR[31:26]
//   zero_i      ALU zero flag
//   mem_ready_i memory completed the current access this cycle
//   ctrl_o      full datapath control vector, including instr_done
// -----------------------------------------------------------------------------
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.i_or_d    = 1'b0;
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_ONE;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        // IR and PC+1 are captured only once the read data is valid.
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end

      ST_DECODE: begin
        // Speculative branch target into ALUOut.
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_SEXT;
        ctrl_o.alu_op    = ALU_ADD;
      end

      ST_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_SEXT;
        ctrl_o.alu_op    = ALU_ADD;
      end

      ST_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end

      ST_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = REGDST_RT;
        ctrl_o.mem_to_reg = M2R_MDR;
        ctrl_o.instr_done = 1'b1;
      end

      ST_MEM_WR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end

      ST_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end

      ST_R_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = REGDST_RD;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
        ctrl_o.instr_done = 1'b1;
      end

      ST_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        case (opcode_i)
          OP_ORI: begin
            ctrl_o.alu_src_b = SRCB_ZEXT;
            ctrl_o.alu_op    = ALU_OR;
          end
          OP_LUI: begin
            ctrl_o.alu_src_b = SRCB_ZEXT;
            ctrl_o.alu_op    = ALU_LUI;
          end
          default: begin
            ctrl_o.alu_src_b = SRCB_SEXT;
            ctrl_o.alu_op    = ALU_ADD;
          end
        endcase
      end

      ST_I_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = REGDST_RT;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
        ctrl_o.instr_done = 1'b1;
      end

      ST_BRANCH: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = SRCB_B;
        ctrl_o.alu_op     = ALU_SUB;
        ctrl_o.pc_source  = PCSRC_ALUOUT;
        // bne takes the branch on a non-zero difference, beq on zero.
        ctrl_o.pc_write   = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
        ctrl_o.instr_done = 1'b1;
      end

      ST_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end

      ST_JAL: begin
        // PC already holds PC+1, which is the return address for r31.
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = REGDST_RA;
        ctrl_o.mem_to_reg = M2R_PC;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end

      ST_JR: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_REG;
        ctrl_o.instr_done = 1'b1;
      end

      default: begin
        // IDLE and HALT drive no enables.
        ctrl_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Main control FSM for the multi-cycle MIPS datapath. Holds the state
// register, next-state logic, the sticky illegal-opcode flag and the
// retired-instruction counter; the control vector comes from
// mc_output_decode.
//
// Ports:
//   clk, reset_n       clock (rising edge), async active-low reset
//   run                allows leaving IDLE / starting the next instruction
//   opcode, funct      IR[31:26], IR[5:0]
//   zero               ALU zero flag
//   mem_ready          memory completed current access this cycle
//   pc_write..pc_source datapath enables and mux selects
//   instr_done         pulse in the last cycle of each instruction
//   illegal            sticky, set on entry to HALT
//   retired            completed-instruction count (wraps silently)
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  ctrl_t            ctrl;

  mc_output_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (run) state_d = ST_FETCH;
      ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
      ST_DECODE:   state_d = decode_next(opcode, funct);
      ST_MEM_ADDR: state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
      ST_R_EXEC:   state_d = ST_R_WB;
      ST_I_EXEC:   state_d = ST_I_WB;
      ST_HALT:     state_d = ST_HALT;
      default: begin
        // Completion states; MEM_WR only completes when memory is ready,
        // which the decoder already folds into instr_done.
        if (ctrl.instr_done) state_d = run ? ST_FETCH : ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_HALT) illegal_q <= 1'b1;
      if (ctrl.instr_done) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign pc_write   = ctrl.pc_write;
  assign ir_write   = ctrl.ir_write;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign reg_write  = ctrl.reg_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign instr_done = ctrl.instr_done;
  assign illegal    = illegal_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed testbench for multicycle_ctrl. Each cycle's full control vector
// is compared against a hand-written expected vector.
// Vector layout: {pc_write, ir_write, i_or_d, mem_read, mem_write,
//                 reg_write, reg_dst[1:0], mem_to_reg[1:0], alu_src_a,
//                 alu_src_b[1:0], alu_op[2:0], pc_source[1:0], instr_done}
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic        alu_src_a, instr_done, illegal;
  logic [2:0]  alu_op;
  logic [31:0] retired;
  logic [18:0] ctrlVec;

  int checks;
  int errors;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .instr_done (instr_done),
    .illegal    (illegal),
    .retired    (retired)
  );

  assign ctrlVec = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
                    reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                    pc_source, instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] mk(input int pcw, input int irw, input int iod,
                                     input int mr, input int mw, input int rw,
                                     input int rd, input int m2r, input int asa,
                                     input int asb, input int aop, input int psrc,
                                     input int done);
    return {1'(pcw), 1'(irw), 1'(iod), 1'(mr), 1'(mw), 1'(rw), 2'(rd), 2'(m2r),
            1'(asa), 2'(asb), 3'(aop), 2'(psrc), 1'(done)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic mr, input logic z,
                               input logic [5:0] op, input logic [5:0] fn);
    run       = r;
    mem_ready = mr;
    zero      = z;
    opcode    = op;
    funct     = fn;
    #1;
  endtask

  // Check this cycle's control vector, then advance to just after the next edge.
  task automatic cycleCheck(input string tag, input logic [18:0] expVec);
    checkOutput(tag, 32'(ctrlVec), 32'(expVec));
    @(posedge clk);
    #1;
  endtask

  logic [18:0] vFetch, vFetchWait, vDecode, vMemAddr, vMemRd, vMemWb;
  logic [18:0] vMemWrWait, vMemWrDone, vRExec, vRWb, vIExecOri, vIExecLui;
  logic [18:0] vIWb, vBrTaken, vBrNot, vJump, vJal, vJr;

  initial begin
    //             pcw irw iod mr mw rw rd m2r asa asb aop psrc done
    vFetch     = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vFetchWait = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vDecode    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    vMemAddr   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    vMemRd     = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vMemWb     = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1);
    vMemWrWait = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vMemWrDone = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    vRExec     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0);
    vRWb       = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    vIExecOri  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 4, 0, 0);
    vIExecLui  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0, 0);
    vIWb       = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    vBrTaken   = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
    vBrNot     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
    vJump      = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
    vJal       = mk(1, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 2, 1);
    vJr        = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);

    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    run       = 1'b0;
    mem_ready = 1'b1;
    zero      = 1'b0;
    opcode    = 6'b0;
    funct     = 6'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ctrl", 32'(ctrlVec), 32'h0);
    checkOutput("rst_illegal", 32'(illegal), 32'h0);
    checkOutput("rst_retired", retired, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cycleCheck("idle_run0", 19'h0);

    // lw, mem_ready always 1: 5 cycles
    applyStimulus(1'b1, 1'b1, 1'b0, 6'b100011, 6'b0);
    cycleCheck("lw_idle", 19'h0);
    cycleCheck("lw_fetch", vFetch);
    cycleCheck("lw_decode", vDecode);
    cycleCheck("lw_memaddr", vMemAddr);
    cycleCheck("lw_memrd", vMemRd);
    checkOutput("lw_retired_pre", retired, 32'd0);
    cycleCheck("lw_memwb", vMemWb);
    checkOutput("lw_retired", retired, 32'd1);

    // sw with mem_ready low for 3 cycles in MEM_WR
    applyStimulus(1'b1, 1'b1, 1'b0, 6'b101011, 6'b0);
    cycleCheck("sw_fetch", vFetch);
    cycleCheck("sw_decode", vDecode);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'b101011, 6'b0);
    cycleCheck("sw_memaddr", vMemAddr);
    for (int i = 0; i < 3; i++) cycleCheck("sw_memwr_wait", vMemWrWait);
    checkOutput("sw_retired_pre", retired, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'b101011, 6'b0);
    cycleCheck("sw_memwr_done", vMemWrDone);
    checkOutput("sw_retired", retired, 32'd2);

    // beq taken, beq not taken, bne taken
    applyStimulus(1'b1, 1'b1, 1'b1, 6'b000100, 6'b0);
    cycleCheck("beq1_fetch", vFetch);
    cycleCheck("beq1_decode", vDecode);
    cycleCheck("beq_taken", vBrTaken);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'b000100, 6'b0);
    cycleCheck("beq2_fetch", vFetch);
    cycleCheck("beq2_decode", vDecode);
    cycleCheck("beq_not_taken", vBrNot);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'b000101, 6'b0);
    cycleCheck("bne_fetch", vFetch);
    cycleCheck("bne_decode", vDecode);
    cycleCheck("bne_taken", vBrTaken);
    checkOutput("br_retired", retired, 32'd5);

    // jal, jr, R-type add
    applyStimulus(1'b1, 1'b1, 1'b0, 6'b000011, 6'b0);
    cycleCheck("jal_fetch", vFetch);
    cycleCheck("jal_decode", vDecode);
    cycleCheck("jal_exec", vJal);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'b000000, 6'b001000);
    cycleCheck("jr_fetch", vFetch);
    cycleCheck("jr_decode", vDecode);
    cycleCheck("jr_exec", vJr);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'b000000, 6'b100000);
    cycleCheck("add_fetch", vFetch);
    cycleCheck("add_decode", vDecode);
    cycleCheck("add_rexec", vRExec);
    cycleCheck("add_rwb", vRWb);
    checkOutput("r_retired", retired, 32'd8);

    // ori, then lui finishing with run=0 -> IDLE
    applyStimulus(1'b1, 1'b1, 1'b0, 6'b001101, 6'b0);
    cycleCheck("ori_fetch", vFetch);
    cycleCheck("ori_decode", vDecode);
    cycleCheck("ori_iexec", vIExecOri);
    cycleCheck("ori_iwb", vIWb);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'b001111, 6'b0);
    cycleCheck("lui_fetch", vFetch);
    cycleCheck("lui_decode", vDecode);
    cycleCheck("lui_iexec", vIExecLui);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'b001111, 6'b0);
    cycleCheck("lui_iwb", vIWb);
    checkOutput("lui_retired", retired, 32'd10);
    cycleCheck("idle_after_done", 19'h0);
    cycleCheck("idle_stay", 19'h0);

    // run=1 from IDLE -> FETCH next cycle; one FETCH wait cycle; j
    applyStimulus(1'b1, 1'b0, 1'b0, 6'b000010, 6'b0);
    cycleCheck("j_idle", 19'h0);
    cycleCheck("j_fetch_wait", vFetchWait);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'b000010, 6'b0);
    cycleCheck("j_fetch", vFetch);
    cycleCheck("j_decode", vDecode);
    cycleCheck("j_exec", vJump);
    checkOutput("j_retired", retired, 32'd11);

    // Illegal opcode -> HALT, sticky until reset
    applyStimulus(1'b1, 1'b1, 1'b0, 6'b111111, 6'b0);
    checkOutput("pre_halt_illegal", 32'(illegal), 32'h0);
    cycleCheck("ill_fetch", vFetch);
    cycleCheck("ill_decode", vDecode);
    checkOutput("halt_illegal", 32'(illegal), 32'h1);
    cycleCheck("halt_ctrl", 19'h0);
    cycleCheck("halt_ctrl_hold", 19'h0);
    checkOutput("halt_illegal_hold", 32'(illegal), 32'h1);
    checkOutput("halt_retired", retired, 32'd11);
    reset_n = 1'b0;
    #1;
    checkOutput("halt_rst_illegal", 32'(illegal), 32'h0);
    checkOutput("halt_rst_retired", retired, 32'd0);
    checkOutput("halt_rst_ctrl", 32'(ctrlVec), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset mid-MEM_RD: outputs drop without a clock edge
    applyStimulus(1'b1, 1'b1, 1'b0, 6'b100011, 6'b0);
    cycleCheck("lw2_idle", 19'h0);
    cycleCheck("lw2_fetch", vFetch);
    cycleCheck("lw2_decode", vDecode);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'b100011, 6'b0);
    cycleCheck("lw2_memaddr", vMemAddr);
    checkOutput("lw2_memrd", 32'(ctrlVec), 32'(vMemRd));
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("midrd_rst_ctrl", 32'(ctrlVec), 32'h0);
    checkOutput("midrd_rst_retired", retired, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
